// File: rtl/mux_n_to_1_reg_if.sv
// Purpose : bundles the N-channel input side and the single output side of
//           mux_n_to_1_reg into one parameterised interface.
// Ports   : in_data/in_valid/in_ready (per-channel handshake), sel/mode
//           (grant control), out_data/out_ch/out_valid/out_ready (output).
// Modports: slave = the mux itself, master = the source/sink around it.
interface mux_n_to_1_reg_if #(
  parameter int WIDTH = 32,
  parameter int CH    = 8,
  parameter int SEL_W = 3
);
  // Channel k occupies in_data[k*WIDTH +: WIDTH].
  logic [CH*WIDTH-1:0] in_data;
  logic [CH-1:0]       in_valid;
  logic [CH-1:0]       in_ready;
  logic [SEL_W-1:0]    sel;
  logic                mode;
  logic [WIDTH-1:0]    out_data;
  logic [SEL_W-1:0]    out_ch;
  logic                out_valid;
  logic                out_ready;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    input  sel,
    input  mode,
    output out_data,
    output out_ch,
    output out_valid,
    input  out_ready
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    output sel,
    output mode,
    input  out_data,
    input  out_ch,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/mux_n_to_1_reg.sv
// Purpose : N-channel, W-bit registered mux with valid/ready on every input
//           and a one-entry output register; optional round-robin arbiter.
// Latency : 1 cycle from input handshake to out_valid; 1 word/cycle sustained.
// Backpres: when the output entry is held (out_valid && !out_ready) all
//           in_ready bits drop to 0 and out_data/out_ch stay stable.
// Ports   : clk, reset (synchronous, active-high), bus (mux_n_to_1_reg_if.slave).
// Config  : define MUX_RR_EN to compile in the round-robin arbiter and its
//           priority pointer; without it the mode input is ignored (treated
//           as 0) and the block is explicit-select only.
module mux_n_to_1_reg #(
  parameter int WIDTH = 32,
  parameter int CH    = 8,
  parameter int SEL_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  mux_n_to_1_reg_if.slave   bus
);

  // ---------------------------------------------------------------------
  // Output entry
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] data_q;
  logic [SEL_W-1:0] ch_q;
  logic             valid_q;

  // The entry may be (re)loaded when it is empty or being drained this cycle.
  logic load_ok;
  assign load_ok = !valid_q || bus.out_ready;

  // ---------------------------------------------------------------------
  // Explicit-select grant: sel >= CH never matches any channel index, so an
  // out-of-range select grants nothing without a separate range compare.
  // ---------------------------------------------------------------------
  logic exp_vld;

  always_comb begin
    exp_vld = 1'b0;
    for (int k = 0; k < CH; k++) begin
      if ((bus.sel == SEL_W'(k)) && bus.in_valid[k]) begin
        exp_vld = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Grant selection
  // ---------------------------------------------------------------------
  logic             gnt_vld;
  logic [SEL_W-1:0] gnt_idx;
  logic             load;

  // A handshake only completes for the granted channel, so a load is simply
  // "some channel is granted and the entry can accept it".
  assign load = gnt_vld && load_ok && !reset;

`ifdef MUX_RR_EN
  // Priority pointer: the last channel served in round-robin mode. The scan
  // starts one past it, so resetting to CH-1 makes channel 0 first.
  logic [SEL_W-1:0] ptr_q;
  logic             rr_mode;
  logic             rr_vld;
  logic [SEL_W-1:0] rr_idx;
  int               rr_best;

  assign rr_mode = bus.mode;

  // Distance of channel k from the scan start (ptr+1), modulo CH. The
  // smallest distance among valid channels is the round-robin winner; this
  // wraps correctly for non-power-of-two CH because only 0..CH-1 are scanned.
  function automatic int rr_dist(input int k, input logic [SEL_W-1:0] p);
    int d;
    d = k - int'(p) - 1;
    if (d < 0) begin
      d = d + CH;
    end
    return d;
  endfunction

  always_comb begin
    rr_vld  = 1'b0;
    rr_idx  = '0;
    rr_best = CH;
    for (int k = 0; k < CH; k++) begin
      if (bus.in_valid[k] && (rr_dist(k, ptr_q) < rr_best)) begin
        rr_best = rr_dist(k, ptr_q);
        rr_idx  = SEL_W'(k);
        rr_vld  = 1'b1;
      end
    end
  end

  assign gnt_vld = rr_mode ? rr_vld : exp_vld;
  assign gnt_idx = rr_mode ? rr_idx : bus.sel;

  // The pointer only advances on round-robin loads; explicit-mode loads and
  // mode switches leave it untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= SEL_W'(CH - 1);
    end else if (load && rr_mode) begin
      ptr_q <= gnt_idx;
    end
  end
`else
  // Mode is not meaningful without the arbiter; it is accepted and dropped.
  logic unused_mode;
  assign unused_mode = bus.mode;

  assign gnt_vld = exp_vld;
  assign gnt_idx = bus.sel;
`endif

  // ---------------------------------------------------------------------
  // Per-channel ready: one-hot on the granted channel, zero otherwise.
  // Reset forces all zeros so no handshake completes in the reset cycle.
  // ---------------------------------------------------------------------
  logic [CH-1:0] in_ready;

  always_comb begin
    in_ready = '0;
    for (int k = 0; k < CH; k++) begin
      if (gnt_vld && load_ok && !reset && (gnt_idx == SEL_W'(k))) begin
        in_ready[k] = 1'b1;
      end
    end
  end

  assign bus.in_ready = in_ready;

  // ---------------------------------------------------------------------
  // Data select: feeds only the output register, never an output directly.
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] gnt_word;

  always_comb begin
    gnt_word = '0;
    for (int k = 0; k < CH; k++) begin
      if (gnt_idx == SEL_W'(k)) begin
        gnt_word = bus.in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output register. A load takes precedence over a drain, which gives the
  // simultaneous drain-and-replace case with out_valid held at 1.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      data_q  <= gnt_word;
      ch_q    <= gnt_idx;
      valid_q <= 1'b1;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_mux_n_to_1_reg.sv
module tb_mux_n_to_1_reg;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mux_n_to_1_reg_if #(.WIDTH(32), .CH(8), .SEL_W(3)) if8 ();
  mux_n_to_1_reg_if #(.WIDTH(16), .CH(5), .SEL_W(3)) if5 ();

  mux_n_to_1_reg #(.WIDTH(32), .CH(8), .SEL_W(3)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (if8.slave)
  );

  mux_n_to_1_reg #(.WIDTH(16), .CH(5), .SEL_W(3)) dut5 (
    .clk   (clk),
    .reset (reset),
    .bus   (if5.slave)
  );

  // Channel words kept in the bench; the model reads these, never the DUT.
  logic [31:0] w8 [8];
  logic [15:0] w5 [5];

  for (genvar k = 0; k < 8; k++) begin : g_pack8
    assign if8.in_data[k*32 +: 32] = w8[k];
  end
  for (genvar k = 0; k < 5; k++) begin : g_pack5
    assign if5.in_data[k*16 +: 16] = w5[k];
  end

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------
  // Which channel the rules grant: explicit = sel if in range and valid;
  // round-robin = first valid scanning ptr+1, ptr+2, ... modulo ch. -1 = none.
  function automatic int grant_of(input int ch, input logic [15:0] v, input int s,
                                  input bit rr, input int p);
    int g;
    g = -1;
    if (!rr) begin
      if (s < ch) begin
        if (v[s]) g = s;
      end
    end else begin
      for (int i = 1; i <= ch; i++) begin
        int idx;
        idx = (p + i) % ch;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    return g;
  endfunction

  function automatic logic [15:0] rdy_of(input int g, input bit held, input bit ordy, input bit rst);
    if (rst || g < 0 || (held && !ordy)) return 16'h0;
    return 16'(1) << g;
  endfunction

  bit rr8, rr5;
`ifdef MUX_RR_EN
  assign rr8 = if8.mode;
  assign rr5 = if5.mode;
`else
  assign rr8 = 1'b0;
  assign rr5 = 1'b0;
`endif

  bit          m8_vld = 1'b0;
  logic [31:0] m8_dat = '0;
  int          m8_ch  = 0;
  int          m8_ptr = 7;
  bit          m5_vld = 1'b0;
  logic [15:0] m5_dat = '0;
  int          m5_ch  = 0;
  int          m5_ptr = 4;
  int          g8, g5;

  always_comb g8 = grant_of(8, {8'h0, if8.in_valid}, int'(if8.sel), rr8, m8_ptr);
  always_comb g5 = grant_of(5, {11'h0, if5.in_valid}, int'(if5.sel), rr5, m5_ptr);

  always @(posedge clk) begin
    if (reset) begin
      m8_vld <= 1'b0; m8_dat <= '0; m8_ch <= 0; m8_ptr <= 7;
    end else if (g8 >= 0 && (!m8_vld || if8.out_ready)) begin
      m8_vld <= 1'b1; m8_dat <= w8[g8]; m8_ch <= g8;
      if (rr8) m8_ptr <= g8;
    end else if (if8.out_ready) begin
      m8_vld <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      m5_vld <= 1'b0; m5_dat <= '0; m5_ch <= 0; m5_ptr <= 4;
    end else if (g5 >= 0 && (!m5_vld || if5.out_ready)) begin
      m5_vld <= 1'b1; m5_dat <= w5[g5]; m5_ch <= g5;
      if (rr5) m5_ptr <= g5;
    end else if (if5.out_ready) begin
      m5_vld <= 1'b0;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m8_in_ready", 64'(if8.in_ready), 64'(rdy_of(g8, m8_vld, if8.out_ready, reset)));
      check("m8_out_valid", 64'(if8.out_valid), 64'(m8_vld));
      if (m8_vld) begin
        check("m8_out_data", 64'(if8.out_data), 64'(m8_dat));
        check("m8_out_ch", 64'(if8.out_ch), 64'(m8_ch));
      end
      check("m5_in_ready", 64'(if5.in_ready), 64'(rdy_of(g5, m5_vld, if5.out_ready, reset)));
      check("m5_out_valid", 64'(if5.out_valid), 64'(m5_vld));
      if (m5_vld) begin
        check("m5_out_data", 64'(if5.out_data), 64'(m5_dat));
        check("m5_out_ch", 64'(if5.out_ch), 64'(m5_ch));
      end
    end
  end

  // ---------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // ---------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    if8.in_valid = '0; if8.sel = '0; if8.mode = 1'b0; if8.out_ready = 1'b0;
    if5.in_valid = '0; if5.sel = '0; if5.mode = 1'b0; if5.out_ready = 1'b0;
    for (int k = 0; k < 8; k++) w8[k] = 32'hA000_0000 + 32'(k) * 32'h0101_0101;
    w8[5] = 32'hDEAD_BEEF;
    for (int k = 0; k < 5; k++) w5[k] = 16'hB000 + 16'(k) * 16'h0111;

    step();
    chk_en = 1'b1;

    // Reset cycle: requests present, but nothing may be accepted.
    if8.in_valid = 8'hFF; if8.out_ready = 1'b1;
    if5.in_valid = 5'h1F; if5.out_ready = 1'b1;
    @(negedge clk);
    check("rst_in_ready8", 64'(if8.in_ready), 64'h0);
    check("rst_in_ready5", 64'(if5.in_ready), 64'h0);
    step();
    check("rst_out_valid", 64'(if8.out_valid), 64'h0);
    check("rst_out_data", 64'(if8.out_data), 64'h0);
    check("rst_out_ch", 64'(if8.out_ch), 64'h0);

    // Explicit select of channel 5.
    reset = 1'b0;
    if8.in_valid = 8'h20; if8.sel = 3'd5;
    if5.in_valid = '0;
    @(negedge clk);
    check("exp_in_ready", 64'(if8.in_ready), 64'h20);
    step();
    check("exp_out_valid", 64'(if8.out_valid), 64'h1);
    check("exp_out_data", 64'(if8.out_data), 64'hDEAD_BEEF);
    check("exp_out_ch", 64'(if8.out_ch), 64'h5);
    if8.in_valid = '0;
    step();
    check("drain_out_valid", 64'(if8.out_valid), 64'h0);

    // Backpressure: load ch2, stall three cycles, then drain + reload ch3.
    if8.in_valid = 8'hFF; if8.sel = 3'd2; if8.out_ready = 1'b0;
    step();
    check("bp_load_ch", 64'(if8.out_ch), 64'h2);
    if8.sel = 3'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(if8.in_ready), 64'h0);
      step();
      check("bp_hold_data", 64'(if8.out_data), 64'hA202_0202);
      check("bp_hold_ch", 64'(if8.out_ch), 64'h2);
    end
    if8.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_rdy", 64'(if8.in_ready), 64'h08);
    step();
    check("bp_reload_valid", 64'(if8.out_valid), 64'h1);
    check("bp_reload_ch", 64'(if8.out_ch), 64'h3);
    check("bp_reload_data", 64'(if8.out_data), 64'hA303_0303);

    // CH=5: selects 5..7 are out of range and grant nothing.
    if5.in_valid = 5'h1F;
    for (int s = 5; s < 8; s++) begin
      if5.sel = 3'(s);
      @(negedge clk);
      check("ch5_oor_in_ready", 64'(if5.in_ready), 64'h0);
      step();
      check("ch5_oor_out_valid", 64'(if5.out_valid), 64'h0);
    end
    if5.sel = 3'd4;
    @(negedge clk);
    check("ch5_top_in_ready", 64'(if5.in_ready), 64'h10);
    step();
    check("ch5_top_out_ch", 64'(if5.out_ch), 64'h4);
    check("ch5_top_out_data", 64'(if5.out_data), 64'hB444);
    if5.in_valid = '0;

    // Reset while the output is stalled.
    if8.in_valid = 8'hFF; if8.sel = 3'd6; if8.mode = 1'b0; if8.out_ready = 1'b1;
    step();
    check("rs_load_ch", 64'(if8.out_ch), 64'h6);
    if8.out_ready = 1'b0;
    step();
    reset = 1'b1;
    @(negedge clk);
    check("rs_in_ready", 64'(if8.in_ready), 64'h0);
    step();
    check("rs_out_valid", 64'(if8.out_valid), 64'h0);
    check("rs_out_data", 64'(if8.out_data), 64'h0);
    check("rs_out_ch", 64'(if8.out_ch), 64'h0);
    reset = 1'b0;

`ifdef MUX_RR_EN
    // Round-robin restarts at 0 and walks 0..7,0 with all channels valid.
    if8.mode = 1'b1; if8.in_valid = 8'hFF; if8.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      check("rr_fair_valid", 64'(if8.out_valid), 64'h1);
      check("rr_fair_ch", 64'(if8.out_ch), 64'(i % 8));
    end
    // Park the pointer on 4, then skip over idle channels: 7,1,4,7.
    if8.in_valid = 8'h10;
    step();
    check("rr_park_ch", 64'(if8.out_ch), 64'h4);
    if8.in_valid = 8'b1001_0010;
    step(); check("rr_skip_0", 64'(if8.out_ch), 64'h7);
    step(); check("rr_skip_1", 64'(if8.out_ch), 64'h1);
    step(); check("rr_skip_2", 64'(if8.out_ch), 64'h4);
    step(); check("rr_skip_3", 64'(if8.out_ch), 64'h7);
    // An explicit load in between leaves the pointer on 7.
    if8.mode = 1'b0; if8.sel = 3'd4;
    step(); check("rr_explicit_ch", 64'(if8.out_ch), 64'h4);
    if8.mode = 1'b1;
    step(); check("rr_resume_ch", 64'(if8.out_ch), 64'h1);
`else
    // Without the arbiter, mode=1 still behaves as explicit select.
    if8.mode = 1'b1; if8.sel = 3'd1; if8.in_valid = 8'hFF; if8.out_ready = 1'b1;
    @(negedge clk);
    check("mode_ign_in_ready", 64'(if8.in_ready), 64'h02);
    step();
    check("mode_ign_out_ch", 64'(if8.out_ch), 64'h1);
    check("mode_ign_out_data", 64'(if8.out_data), 64'hA101_0101);
    if8.sel = 3'd7;
    step();
    check("mode_ign_out_ch2", 64'(if8.out_ch), 64'h7);
`endif

    if8.in_valid = '0; if8.mode = 1'b0;
    step();
    check("final_drain", 64'(if8.out_valid), 64'h0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
